// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path.
package i2s_pkg;

    localparam int CHAN_LEFT      = 0;
    localparam int CHAN_RIGHT     = 1;
    localparam int CHAN_BOTH      = 2;
    localparam int DEF_IN_WIDTH   = 18;
    localparam int DEF_OUT_WIDTH  = 24;

    // One buffered sample at the default output width, channel in the MSB.
    typedef struct packed {
        logic                     chan;
        logic [DEF_OUT_WIDTH-1:0] data;
    } sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and no fall-through; a push is
// accepted when full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign valid_o = ~empty;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/i2s_rx_sync.sv
// Brings deserialized I2S words into the system clock domain, tags them with
// their channel, optionally filters by channel and buffers them for the DSP.
module i2s_rx_sync
    import i2s_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CHAN_SEL   = CHAN_BOTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  i2s_data,
    input  logic                 i2s_word_ready,
    input  logic                 i2s_lrclk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_chan,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int W = OUT_WIDTH + 1;

    logic wr_s1_q, wr_s2_q, wr_d_q;
    logic lr_s1_q, lr_s2_q;
    logic overflow_q, overflow_d;

    logic                 cap;
    logic                 cap_chan;
    logic                 pass_filter;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic [OUT_WIDTH-1:0] ext_data;
    logic [W-1:0]         head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_s1_q    <= 1'b0;
            wr_s2_q    <= 1'b0;
            wr_d_q     <= 1'b0;
            lr_s1_q    <= 1'b0;
            lr_s2_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_s1_q    <= i2s_word_ready;
            wr_s2_q    <= wr_s1_q;
            wr_d_q     <= wr_s2_q;
            lr_s1_q    <= i2s_lrclk;
            lr_s2_q    <= lr_s1_q;
            overflow_q <= overflow_d;
        end
    end

    // LRCLK has already toggled when word_ready rises, so the finished word
    // belongs to the opposite level. The data bus is quasi-static here and is
    // sampled without its own synchroniser.
    assign cap      = wr_s2_q & ~wr_d_q;
    assign cap_chan = ~lr_s2_q;
    assign ext_data = OUT_WIDTH'($signed(i2s_data));

    assign pass_filter = (CHAN_SEL == CHAN_BOTH) ||
                         (cap_chan == (CHAN_SEL == CHAN_RIGHT));
    assign push        = cap & pass_filter;
    assign pop         = out_valid & out_ready;

    // A new drop outranks a simultaneous clear.
    assign overflow_d  = (push & fifo_full & ~pop) | (overflow_q & ~overflow_clr);

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({cap_chan, ext_data}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (out_valid),
        .full_o      (fifo_full)
    );

    assign out_chan = head[OUT_WIDTH];
    assign out_data = head[OUT_WIDTH-1:0];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Directed bench for i2s_rx_sync: a both-channel instance and a right-only instance.
module tb_i2s_rx_sync;
    import i2s_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] i2s_data = '0;
    logic        i2s_word_ready = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        out_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        out_valid, out_chan, overflow;
    logic [23:0] out_data;

    logic        r_ready = 1'b1;
    logic        r_clr = 1'b0;
    logic        r_valid, r_chan, r_overflow;
    logic [23:0] r_data;

    int checks = 0;
    int failures = 0;

    sample_t q[$];
    sample_t rq[$];

    always #10 clk = ~clk;

    i2s_rx_sync #(.IN_WIDTH(18), .OUT_WIDTH(24), .FIFO_DEPTH(4), .CHAN_SEL(2)) dut (
        .clk(clk), .rst(rst), .i2s_data(i2s_data), .i2s_word_ready(i2s_word_ready),
        .i2s_lrclk(i2s_lrclk), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .overflow(overflow),
        .overflow_clr(overflow_clr));

    i2s_rx_sync #(.IN_WIDTH(18), .OUT_WIDTH(24), .FIFO_DEPTH(4), .CHAN_SEL(1)) dut_r (
        .clk(clk), .rst(rst), .i2s_data(i2s_data), .i2s_word_ready(i2s_word_ready),
        .i2s_lrclk(i2s_lrclk), .out_valid(r_valid), .out_ready(r_ready),
        .out_data(r_data), .out_chan(r_chan), .overflow(r_overflow),
        .overflow_clr(r_clr));

    // Record every accepted output beat, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) q.push_back({out_chan, out_data});
            if (r_valid && r_ready) rq.push_back({r_chan, r_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Deserializer model: bus shifts while word_ready is low, settles, then
    // word_ready rises together with the LRCLK toggle and is held one BCLK.
    task automatic send_word(input logic chan, input logic [17:0] d,
                             input bit lat_chk, input bit clr_at_push,
                             input bit rdy_at_push);
        int lat;
        for (int j = 1; j <= 4; j++) begin
            tick();
            i2s_data = d >> (18 - 4 * j);
        end
        tick();
        i2s_data = d;
        tick();
        i2s_word_ready = 1'b1;
        i2s_lrclk = ~chan;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 2) begin
                if (clr_at_push) overflow_clr = 1'b1;
                if (rdy_at_push) out_ready = 1'b1;
            end
            if (k == 3) begin
                if (clr_at_push) overflow_clr = 1'b0;
                if (rdy_at_push) out_ready = 1'b0;
            end
            if (out_valid && lat < 0) lat = k;
        end
        if (lat_chk) begin
            checks++;
            if (lat < 3 || lat > 5) begin
                failures++;
                $display("FAIL latency got=%0d cycles exp=3..5", lat);
            end
        end
        i2s_word_ready = 1'b0;
        repeat (6) begin
            tick();
            i2s_data = 18'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== 24'h0) begin failures++; $display("FAIL rst_data got=%h exp=000000", out_data); end
        checks++;
        if (out_chan !== 1'b0) begin failures++; $display("FAIL rst_chan got=%b exp=0", out_chan); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        sample_t exp [2];
        exp[0] = {1'b0, 24'hFFFFFF};
        exp[1] = {1'b1, 24'h000001};
        q.delete();
        out_ready = 1'b1;
        send_word(1'b0, 18'h3FFFF, 1'b1, 1'b0, 1'b0);
        send_word(1'b1, 18'h00001, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        checks++;
        if (q.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_sample[%0d] got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_chan_filter();
        rq.delete();
        out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            send_word(1'b0, 18'h00010, 1'b0, 1'b0, 1'b0);
            send_word(1'b1, 18'h20000, 1'b0, 1'b0, 1'b0);
        end
        repeat (4) tick();
        checks++;
        if (rq.size() != 4) begin failures++; $display("FAIL filter_count got=%0d exp=4", rq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= rq.size() || rq[i] !== {1'b1, 24'hFE0000}) begin
                failures++;
                $display("FAIL filter_sample[%0d] got=%h exp=1fe0000", i, (i < rq.size()) ? rq[i] : '0);
            end
        end
        checks++;
        if (r_overflow !== 1'b0) begin failures++; $display("FAIL filter_overflow got=%b exp=0", r_overflow); end
    endtask

    task automatic test_overflow();
        logic [17:0] din [6];
        sample_t     exp [4];
        din[0] = 18'h00011; din[1] = 18'h3FFF0; din[2] = 18'h12345;
        din[3] = 18'h2ABCD; din[4] = 18'h00055; din[5] = 18'h00066;
        exp[0] = {1'b0, 24'h000011}; exp[1] = {1'b1, 24'hFFFFF0};
        exp[2] = {1'b0, 24'h012345}; exp[3] = {1'b1, 24'hFEABCD};
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(1'(i % 2), din[i], 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_at_full got=%b exp=0", overflow); end
        checks++;
        if (out_valid !== 1'b1 || {out_chan, out_data} !== exp[0]) begin
            failures++;
            $display("FAIL ovf_head got=%b/%h exp=1/%h", out_valid, {out_chan, out_data}, exp[0]);
        end
        send_word(1'b0, din[4], 1'b0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        send_word(1'b1, din[5], 1'b0, 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_beats_clr got=%b exp=1", overflow); end
        checks++;
        if ({out_chan, out_data} !== exp[0]) begin
            failures++;
            $display("FAIL ovf_head_hold got=%h exp=%h", {out_chan, out_data}, exp[0]);
        end
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        out_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (q.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                failures++;
                $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_full_pushpop();
        sample_t exp [5];
        exp[0] = {1'b0, 24'h000001}; exp[1] = {1'b1, 24'h000002};
        exp[2] = {1'b0, 24'h000003}; exp[3] = {1'b1, 24'h000004};
        exp[4] = {1'b0, 24'hFFFFFE};
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(1'(i % 2), 18'(i + 1), 1'b0, 1'b0, 1'b0);
        send_word(1'b0, 18'h3FFFE, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
        checks++;
        if (q.size() != 1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pp_single_pop got=%0d/%b exp=1/1", q.size(), out_valid);
        end
        out_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (q.size() != 5) begin failures++; $display("FAIL pp_count got=%0d exp=5", q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                failures++;
                $display("FAIL pp_sample[%0d] got=%h exp=%h", i, (i < q.size()) ? q[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_hold_level();
        q.delete();
        out_ready = 1'b1;
        tick();
        i2s_data = 18'h01234;
        tick();
        i2s_word_ready = 1'b1;
        i2s_lrclk = 1'b0;
        repeat (40) tick();
        i2s_word_ready = 1'b0;
        repeat (8) tick();
        checks++;
        if (q.size() != 1 || q[0] !== {1'b1, 24'h001234}) begin
            failures++;
            $display("FAIL hold_level got=%0d/%h exp=1/1001234", q.size(), (q.size() > 0) ? q[0] : '0);
        end
    endtask

    task automatic test_shifting();
        q.delete();
        out_ready = 1'b1;
        send_word(1'b0, 18'h2AAAA, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 24'hFEAAAA}) begin
            failures++;
            $display("FAIL shifting got=%0d/%h exp=1/0feaaaa", q.size(), (q.size() > 0) ? q[0] : '0);
        end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        send_word(1'b1, 18'h00077, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async got=%b exp=0", out_valid); end
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0) begin
            failures++;
            $display("FAIL midrst_empty got=%b/%h exp=0/000000", out_valid, out_data);
        end
        q.delete();
        out_ready = 1'b1;
        send_word(1'b0, 18'h3FF00, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        checks++;
        if (q.size() != 1 || q[0] !== {1'b0, 24'hFFFF00}) begin
            failures++;
            $display("FAIL midrst_next got=%0d/%h exp=1/0ffff00", q.size(), (q.size() > 0) ? q[0] : '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chan_filter();
        test_overflow();
        test_full_pushpop();
        test_hold_level();
        test_shifting();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
